uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-requester scheduler in front of the UART transmitter. It drains two byte FIFOs: requester 0 is the SDRAM read-back FIFO and requester 1 is the status/debug FIFO. It feeds one byte at a time to the transmitter through its `tx_data`/`tx_trig` interface, then waits for the frame to finish before issuing the next byte. Arbitration is round-robin with a bounded burst per grant, so neither source starves the serial port.

## Interface
Parameters:
- `BURST_MAX`, default 16: maximum consecutive bytes granted to one requester while the other is waiting; legal range 1..255.
- `TRIG_LEN`, default 3: cycles `tx_trig` is held high per byte; minimum 3.
- `GAP_CYCLES`, default 2: idle cycles after a frame completes before the next arbitration; 0 is legal.

Ports:
- `sclk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: reset, **synchronous, active-low**.
- `req0_empty` in 1: requester 0 FIFO empty.
- `req0_rd_en` out 1: requester 0 FIFO read strobe, one-cycle pulse.
- `req0_data` in 8: requester 0 FIFO read data, valid the cycle after `req0_rd_en`.
- `req1_empty`, `req1_rd_en`, `req1_data`: the same three signals for requester 1.
- `tx_data` out 8: byte to the transmitter; held stable from TRIG entry until the next LOAD.
- `tx_trig` out 1: start request to the transmitter.
- `tx_busy` in 1: transmitter frame-in-progress flag.
- `grant` out 2: one-hot owner of the current or last byte; 2'b00 after reset until the first grant.
- `sched_busy` out 1: high in every state except IDLE.
- `tx_err` out 1: one-cycle pulse on transmitter timeout; 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, READ, LOAD, TRIG, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE**: if either `empty` is low, pick the owner, pulse that requester's `rd_en`, and go to READ.
- **READ**: one cycle, waiting for FIFO read latency; go to LOAD.
- **LOAD**: capture the selected `reqN_data` into the `tx_data` register; go to TRIG.
- **TRIG**: `tx_trig`=1 for exactly `TRIG_LEN` cycles, then go to WAIT_BUSY with `tx_trig`=0.
- **WAIT_BUSY**: wait for `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_busy`=0. If `GAP_CYCLES`>0 go to GAP, else go to IDLE.
- **GAP**: count `GAP_CYCLES` cycles, then go to IDLE.
- Arbitration is evaluated only in IDLE:
  - If only one requester is non-empty, grant it.
  - If both are non-empty, keep the current owner while its burst count is below `BURST_MAX`; otherwise switch to the other requester.
  - With no previous owner, requester 0 wins.
- Burst counter (8 bits):
  - Reset to 1 on an owner switch.
  - Incremented on each byte to the same owner, saturating at `BURST_MAX`.
  - Reset to 0 when both FIFOs are empty in IDLE.
- Exactly one `rd_en` pulse per byte. `rd_en` is never asserted outside the IDLE→READ transition. `rd_en` is never asserted to a requester whose `empty` is high in that cycle.
- The `empty` inputs are ignored outside IDLE. A FIFO becoming non-empty mid-frame is served at the next IDLE.

## Timing
- Reset values: `req0_rd_en`=0, `req1_rd_en`=0, `tx_trig`=0, `tx_data`=8'h00, `grant`=2'b00, `sched_busy`=0, `tx_err`=0. The FSM resets to IDLE. All counters reset to 0.
- Reset low in any state forces these values on the next edge, including mid-TRIG, where `tx_trig` drops immediately. A byte already popped from a FIFO is discarded.
- Latency from `empty` low in IDLE to the first `tx_trig` high is 3 edges: rd_en, READ, LOAD.
- `grant` updates on the same edge as `rd_en`.
- `sched_busy` rises on the same edge as `rd_en`.
- Minimum byte-to-byte spacing is `TRIG_LEN` + transmitter frame time + `GAP_CYCLES` + 4 cycles.
- If `tx_busy` is already 1 on WAIT_BUSY entry, the FSM moves to WAIT_DONE on the next edge.

## Configuration
- Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- **Defined**: a 5-bit counter runs in WAIT_BUSY. If `tx_busy` has not risen 16 cycles after WAIT_BUSY entry:
  - `tx_err` pulses for 1 cycle;
  - the byte is dropped;
  - the FSM goes to GAP, or to IDLE if `GAP_CYCLES`=0;
  - the burst count still advances.
- **Not defined**: WAIT_BUSY waits indefinitely and `tx_err` is tied to 0.

## Test plan
- **Single byte.** Stimulus: reset, then req0 holds 8'hA5 and req1 is empty; transmitter model raises `tx_busy` 3 cycles after `tx_trig` rises and holds it 200 cycles.
  - Required: `req0_rd_en` pulses once; `tx_data`=8'hA5 with `tx_trig` high for 3 cycles; `grant`=2'b01; back to IDLE with `sched_busy`=0 after 2 gap cycles.
- **Burst limit.** Stimulus: `BURST_MAX`=4; req0 holds 10 bytes (8'h00..8'h09); req1 holds 3 bytes (8'hF0..8'hF2).
  - Required byte order: 00,01,02,03,F0,F1,F2,04..09.
- **Lone requester.** Stimulus: only req1 non-empty with 6 bytes; `BURST_MAX`=2.
  - Required: all 6 bytes are sent from req1 back-to-back with no owner switch; `grant` stays 2'b10.
- **Reset mid-TRIG.** Stimulus: drive `reset`=0 during the second `tx_trig` cycle.
  - Required: the next edge shows `tx_trig`=0, `grant`=2'b00, state IDLE; no further `rd_en` until `reset`=1.
- **Timeout, with `UART_TX_SCHED_TIMEOUT_EN` defined.** Stimulus: `tx_busy` stuck at 0.
  - Required: `tx_err` pulses exactly 16 cycles after WAIT_BUSY entry, and the next queued byte is then sent normally.
- **Timeout, with the macro not defined.** Same stimulus.
  - Required: the FSM stays in WAIT_BUSY and `tx_err` stays 0.
- **Simultaneous arrival.** Stimulus: both FIFOs go non-empty in the same cycle after reset.
  - Required: req0 is granted first.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that drains two byte FIFOs into a UART transmitter.
// Optional transmitter timeout when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
  parameter int BURST_MAX  = 16,
  parameter int TRIG_LEN   = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       req0_empty,
  output logic       req0_rd_en,
  input  logic [7:0] req0_data,
  input  logic       req1_empty,
  output logic       req1_rd_en,
  input  logic [7:0] req1_data,
  output logic [7:0] tx_data,
  output logic       tx_trig,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       sched_busy,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_TRIG, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  localparam logic [7:0]  BURST_LIMIT = 8'(BURST_MAX);
  localparam logic [15:0] TRIG_LAST   = 16'(TRIG_LEN - 1);
  localparam logic [15:0] GAP_LAST    = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit          HAS_GAP     = (GAP_CYCLES > 0);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_burstCount;
  logic [1:0]  r_grant;
  logic        r_rd0;
  logic        r_rd1;
  logic        r_trig;
  logic [7:0]  r_txData;
  logic        r_schedBusy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [4:0]  r_timeout;
  logic        r_txErr;
`endif

  logic        w_anyReq;
  logic        w_pick0;
  logic        w_sameOwner;
  logic [7:0]  w_burstNext;
  state_t      w_afterFrame;

  // Owner choice and burst bookkeeping; only consumed while in IDLE.
  always_comb begin
    w_anyReq     = !req0_empty || !req1_empty;
    w_pick0      = 1'b0;
    w_afterFrame = HAS_GAP ? S_GAP : S_IDLE;
    if (!req0_empty && req1_empty) begin
      w_pick0 = 1'b1;
    end else if (req0_empty && !req1_empty) begin
      w_pick0 = 1'b0;
    end else if (!req0_empty && !req1_empty) begin
      if (r_grant == 2'b00) begin
        w_pick0 = 1'b1;
      end else if (r_burstCount < BURST_LIMIT) begin
        w_pick0 = r_grant[0];
      end else begin
        w_pick0 = !r_grant[0];
      end
    end
    w_sameOwner = w_pick0 ? r_grant[0] : r_grant[1];
    if (!w_sameOwner) begin
      w_burstNext = 8'd1;
    end else if (r_burstCount >= BURST_LIMIT) begin
      w_burstNext = BURST_LIMIT;
    end else begin
      w_burstNext = r_burstCount + 8'd1;
    end
  end

  always_ff @(posedge sclk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_burstCount <= 8'd0;
      r_grant      <= 2'b00;
      r_rd0        <= 1'b0;
      r_rd1        <= 1'b0;
      r_trig       <= 1'b0;
      r_txData     <= 8'h00;
      r_schedBusy  <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      r_timeout    <= 5'd0;
      r_txErr      <= 1'b0;
`endif
    end else begin
      r_rd0 <= 1'b0;
      r_rd1 <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      r_txErr <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_rd0        <= w_pick0;
            r_rd1        <= !w_pick0;
            r_grant      <= w_pick0 ? 2'b01 : 2'b10;
            r_burstCount <= w_burstNext;
            r_schedBusy  <= 1'b1;
            r_state      <= S_READ;
          end else begin
            r_burstCount <= 8'd0;
          end
        end
        S_READ: r_state <= S_LOAD;
        S_LOAD: begin
          r_txData <= r_grant[0] ? req0_data : req1_data;
          r_trig   <= 1'b1;
          r_cnt    <= 16'd0;
          r_state  <= S_TRIG;
        end
        S_TRIG: begin
          if (r_cnt == TRIG_LAST) begin
            r_trig  <= 1'b0;
            r_state <= S_WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_timeout <= 5'd0;
`endif
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          // Transmitter never started: drop the byte and carry on.
          else if (r_timeout == 5'd15) begin
            r_txErr <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= w_afterFrame;
            if (!HAS_GAP) r_schedBusy <= 1'b0;
          end else begin
            r_timeout <= r_timeout + 5'd1;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_cnt   <= 16'd0;
            r_state <= w_afterFrame;
            if (!HAS_GAP) r_schedBusy <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state     <= S_IDLE;
            r_schedBusy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_schedBusy <= 1'b0;
        end
      endcase
    end
  end

  assign req0_rd_en = r_rd0;
  assign req1_rd_en = r_rd1;
  assign tx_data    = r_txData;
  assign tx_trig    = r_trig;
  assign grant      = r_grant;
  assign sched_busy = r_schedBusy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign tx_err     = r_txErr;
`else
  assign tx_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: FIFO and transmitter models, vector table, scoreboard.
module tb_uart_tx_sched;

  typedef struct {
    int         scen;
    bit         src;
    logic [7:0] din;
    logic [1:0] expGrant;
    logic [7:0] expData;
  } vec_t;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
  } exp_t;

  logic       sclk = 1'b0;
  logic       resetN;
  logic       req0Empty, req1Empty, req0RdEn, req1RdEn;
  logic [7:0] req0Data, req1Data, txData;
  logic       txTrig, txBusy, schedBusy, txErr;
  logic [1:0] grant;

  always #5 sclk = ~sclk;

  uart_tx_sched #(.BURST_MAX(4), .TRIG_LEN(3), .GAP_CYCLES(2)) dut (
    .sclk(sclk), .reset(resetN),
    .req0_empty(req0Empty), .req0_rd_en(req0RdEn), .req0_data(req0Data),
    .req1_empty(req1Empty), .req1_rd_en(req1RdEn), .req1_data(req1Data),
    .tx_data(txData), .tx_trig(txTrig), .tx_busy(txBusy),
    .grant(grant), .sched_busy(schedBusy), .tx_err(txErr)
  );

  // FIFO models: the bench owns the tails, the read process owns the heads.
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  logic [7:0] tail0 = 8'd0, tail1 = 8'd0, head0 = 8'd0, head1 = 8'd0;
  int         viol0 = 0, viol1 = 0;
  assign req0Empty = (head0 == tail0);
  assign req1Empty = (head1 == tail1);

  always @(posedge sclk) begin
    if (req0RdEn) begin
      if (head0 == tail0) viol0 <= viol0 + 1;
      req0Data <= mem0[head0];
      head0    <= head0 + 8'd1;
    end
    if (req1RdEn) begin
      if (head1 == tail1) viol1 <= viol1 + 1;
      req1Data <= mem1[head1];
      head1    <= head1 + 8'd1;
    end
  end

  // Transmitter model: busy rises 3 edges after tx_trig rises and holds busyHold cycles.
  bit   busyStuck = 1'b0;
  int   busyHold  = 20;
  logic prevTrigP = 1'b0;
  int   dly = 0, holdCnt = 0;
  initial txBusy = 1'b0;

  always @(posedge sclk) begin
    prevTrigP <= txTrig;
    if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        txBusy  <= 1'b1;
        holdCnt <= busyHold;
      end
    end else if (txBusy) begin
      if (holdCnt <= 1) txBusy <= 1'b0;
      else holdCnt <= holdCnt - 1;
    end
    if (txTrig && !prevTrigP && !busyStuck && !txBusy && dly == 0) dly <= 2;
  end

  vec_t vecs [0:20];
  exp_t expQ [$];
  int   total = 0, bad = 0, rdCount = 0, protoViol = 0, trigLen = 0;
  bit   prevTrig = 1'b0, trigAbort = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every wait goes through here so the scoreboard watches all cycles.
  task automatic tick();
    exp_t e;
    @(negedge sclk);
    if (req0RdEn) rdCount++;
    if (req1RdEn) rdCount++;
    if (req0RdEn && req1RdEn) protoViol++;
    if (!resetN && (req0RdEn || req1RdEn)) protoViol++;
    if (!resetN) trigAbort = 1'b1;
    if (txTrig && !prevTrig) begin
      trigLen   = 1;
      trigAbort = !resetN;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_byte", 32'(txData), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("byte_data", 32'(txData), 32'(e.data));
        checkOutput("byte_grant", 32'(grant), 32'(e.grant));
      end
    end else if (txTrig) begin
      trigLen++;
    end
    if (!txTrig && prevTrig && !trigAbort) checkOutput("trig_len", 32'(trigLen), 32'd3);
    prevTrig = txTrig;
  endtask

  task automatic applyStimulus(input bit src, input logic [7:0] din,
                               input logic [1:0] eg, input logic [7:0] ed);
    exp_t e;
    if (!src) begin
      mem0[tail0] = din;
      tail0 = tail0 + 8'd1;
    end else begin
      mem1[tail1] = din;
      tail1 = tail1 + 8'd1;
    end
    e.grant = eg;
    e.data  = ed;
    expQ.push_back(e);
  endtask

  task automatic setVec(input int idx, input int scen, input bit src, input logic [7:0] din,
                        input logic [1:0] eg, input logic [7:0] ed);
    vecs[idx].scen     = scen;
    vecs[idx].src      = src;
    vecs[idx].din      = din;
    vecs[idx].expGrant = eg;
    vecs[idx].expData  = ed;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    repeat (2) tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while ((expQ.size() != 0 || schedBusy || txBusy) && n < 3000) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(n < 3000), 32'd1);
  endtask

  task automatic waitTrig(input logic lvl, input string name);
    int n = 0;
    while (txTrig !== lvl && n < 60) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(txTrig), 32'(lvl));
  endtask

  initial begin
    int nPush, rdBefore, errCnt, idleCnt;

    // Burst limit (BURST_MAX=4): inputs in push order, expected in send order.
    for (int k = 0; k < 10; k++)
      setVec(k, 0, 1'b0, 8'(k), (k >= 4 && k <= 6) ? 2'b10 : 2'b01,
             (k < 4) ? 8'(k) : (k <= 6) ? 8'(8'hF0 + k - 4) : 8'(k - 3));
    setVec(10, 0, 1'b1, 8'hF0, 2'b01, 8'h07);
    setVec(11, 0, 1'b1, 8'hF1, 2'b01, 8'h08);
    setVec(12, 0, 1'b1, 8'hF2, 2'b01, 8'h09);
    // Lone requester: req1 only, no owner switch.
    for (int k = 0; k < 6; k++)
      setVec(13 + k, 1, 1'b1, 8'(8'hB0 + k), 2'b10, 8'(8'hB0 + k));
    // Simultaneous arrival right after reset.
    setVec(19, 2, 1'b0, 8'h11, 2'b01, 8'h11);
    setVec(20, 2, 1'b1, 8'h22, 2'b10, 8'h22);

    resetN = 1'b0;
    repeat (3) tick();
    checkOutput("rst_trig", 32'(txTrig), 32'd0);
    checkOutput("rst_data", 32'(txData), 32'h00);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(schedBusy), 32'd0);
    checkOutput("rst_rd", 32'({req1RdEn, req0RdEn}), 32'd0);
    checkOutput("rst_err", 32'(txErr), 32'd0);
    resetN = 1'b1;
    tick();

    $display("[TB] single byte");
    busyHold = 200;
    rdCount  = 0;
    applyStimulus(1'b0, 8'hA5, 2'b01, 8'hA5);
    tick();
    checkOutput("single_rd0", 32'(req0RdEn), 32'd1);
    checkOutput("single_grant", 32'(grant), 32'd1);
    checkOutput("single_busy_rise", 32'(schedBusy), 32'd1);
    tick();
    checkOutput("single_rd0_pulse", 32'(req0RdEn), 32'd0);
    checkOutput("single_trig_early", 32'(txTrig), 32'd0);
    tick();
    checkOutput("single_trig_latency", 32'(txTrig), 32'd1);
    begin
      int n = 0;
      while (!txBusy && n < 50) begin tick(); n++; end
      while (txBusy && n < 500) begin tick(); n++; end
      checkOutput("single_frame_end", 32'(n < 500), 32'd1);
    end
    tick();
    tick();
    checkOutput("single_gap_hold", 32'(schedBusy), 32'd1);
    tick();
    checkOutput("single_idle", 32'(schedBusy), 32'd0);
    checkOutput("single_rdcount", 32'(rdCount), 32'd1);
    busyHold = 20;

    for (int s = 0; s < 3; s++) begin
      $display("[TB] table scenario %0d", s);
      doReset();
      rdCount = 0;
      nPush   = 0;
      for (int i = 0; i < 21; i++) begin
        if (vecs[i].scen == s) begin
          applyStimulus(vecs[i].src, vecs[i].din, vecs[i].expGrant, vecs[i].expData);
          nPush++;
        end
      end
      waitDone("table_drain");
      checkOutput("table_rdcount", 32'(rdCount), 32'(nPush));
    end

    $display("[TB] reset mid-trig");
    doReset();
    rdCount = 0;
    applyStimulus(1'b0, 8'h3C, 2'b01, 8'h3C);
    waitTrig(1'b1, "rst_mid_trig_seen");
    tick();
    resetN = 1'b0;
    tick();
    checkOutput("rst_mid_trig", 32'(txTrig), 32'd0);
    checkOutput("rst_mid_grant", 32'(grant), 32'd0);
    checkOutput("rst_mid_busy", 32'(schedBusy), 32'd0);
    applyStimulus(1'b0, 8'h5A, 2'b01, 8'h5A);
    rdBefore = rdCount;
    repeat (30) tick();
    checkOutput("rst_mid_no_rd", 32'(rdCount - rdBefore), 32'd0);
    resetN = 1'b1;
    waitDone("rst_mid_drain");
    checkOutput("rst_mid_rdcount", 32'(rdCount), 32'd2);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    $display("[TB] timeout enabled");
    doReset();
    rdCount   = 0;
    busyStuck = 1'b1;
    applyStimulus(1'b0, 8'h77, 2'b01, 8'h77);
    applyStimulus(1'b0, 8'h78, 2'b01, 8'h78);
    waitTrig(1'b1, "tmo_trig_rise");
    waitTrig(1'b0, "tmo_trig_fall");
    errCnt = 0;
    repeat (15) begin
      tick();
      if (txErr) errCnt++;
    end
    checkOutput("tmo_early_err", 32'(errCnt), 32'd0);
    tick();
    checkOutput("tmo_err_pulse", 32'(txErr), 32'd1);
    busyStuck = 1'b0;
    tick();
    checkOutput("tmo_err_width", 32'(txErr), 32'd0);
    waitDone("tmo_drain");
    checkOutput("tmo_rdcount", 32'(rdCount), 32'd2);
`else
    $display("[TB] timeout disabled");
    doReset();
    rdCount   = 0;
    busyStuck = 1'b1;
    applyStimulus(1'b0, 8'h77, 2'b01, 8'h77);
    waitTrig(1'b1, "notmo_trig_rise");
    waitTrig(1'b0, "notmo_trig_fall");
    errCnt  = 0;
    idleCnt = 0;
    repeat (40) begin
      tick();
      if (txErr) errCnt++;
      if (!schedBusy) idleCnt++;
    end
    checkOutput("notmo_err", 32'(errCnt), 32'd0);
    checkOutput("notmo_stays_busy", 32'(idleCnt), 32'd0);
    checkOutput("notmo_rdcount", 32'(rdCount), 32'd1);
    busyStuck = 1'b0;
    doReset();
`endif

    checkOutput("protocol_violations", 32'(protoViol + viol0 + viol1), 32'd0);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
